// File: rtl/step_sequencer.sv
// Purpose: 4-track x 16-step drum sequencer driven by a PS/2 scan-code byte stream.
// Latency: a decoded byte takes effect on the next clock edge; gates follow pattern/step combinationally.
// Backpressure: none; one byte is accepted on every cycle sim_data_en is high.
// Ports: CLOCK_50 clock; KEY[0] async active-low reset (KEY[2:1] unused);
//        sim_data[7:0]/sim_data_en scan-code bytes (sim_data[8] unused);
//        LEDR {edit, playing, step[3:0], gates[3:0]}; HEX5..HEX0 active-low 7-segment.
module step_sequencer #(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic       CLOCK_50,
  input  logic [2:0] KEY,
  input  logic [8:0] sim_data,
  input  logic       sim_data_en,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  // One step is a quarter beat: stepping every CLK_HZ*60/(BPM*4) cycles.
  localparam logic [31:0] ACC_LIMIT = 32'(64'(CLK_HZ) * 64'd60);
  localparam logic [6:0]  SEG_OFF   = 7'h7F;

  typedef enum logic [1:0] {M_IDLE, M_BPM, M_LEN, M_EDIT} mode_t;

  logic             rst_n;
  logic             unused_in;
  logic [7:0]       code;

  mode_t            mode;
  logic             brk;
  logic [9:0]       bpm;
  logic [4:0]       len;
  logic [3:0][15:0] pat;
  logic [1:0]       cur_trk;
  logic [3:0]       cur_col;
  logic             playing;
  logic [3:0]       step;
  logic [31:0]      acc;
  logic [9:0]       entry_val;
  logic [1:0]       dcnt;

  logic             dig_vld;
  logic [3:0]       dig_val;
  logic [1:0]       dig_max;
  logic [9:0]       entry_nxt;
  logic             len_ok;
  logic [31:0]      acc_inc;
  logic             adv;
  logic [3:0]       step_inc;
  logic [3:0]       step_nxt;
  logic [3:0]       gates;
  logic [9:0]       bpm_disp;
  logic [11:0]      bpm_bcd;
  logic [6:0]       len_disp;
  logic [7:0]       len_bcd;

  assign rst_n     = KEY[0];
  assign unused_in = ^{KEY[2:1], sim_data[8]};
  assign code      = sim_data[7:0];

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // Double-dabble, 10-bit binary to three BCD digits (input never exceeds 999).
  function automatic logic [11:0] to_bcd3(input logic [9:0] v);
    logic [21:0] s;
    s = {12'd0, v};
    for (int i = 0; i < 10; i++) begin
      if (s[13:10] >= 4'd5) s[13:10] = s[13:10] + 4'd3;
      if (s[17:14] >= 4'd5) s[17:14] = s[17:14] + 4'd3;
      if (s[21:18] >= 4'd5) s[21:18] = s[21:18] + 4'd3;
      s = s << 1;
    end
    return s[21:10];
  endfunction

  // Double-dabble, 7-bit binary to two BCD digits (input never exceeds 99).
  function automatic logic [7:0] to_bcd2(input logic [6:0] v);
    logic [14:0] s;
    s = {8'd0, v};
    for (int i = 0; i < 7; i++) begin
      if (s[10:7]  >= 4'd5) s[10:7]  = s[10:7]  + 4'd3;
      if (s[14:11] >= 4'd5) s[14:11] = s[14:11] + 4'd3;
      s = s << 1;
    end
    return s[14:7];
  endfunction

  always_comb begin
    dig_vld = 1'b1;
    dig_val = 4'd0;
    case (code)
      8'h45:   dig_val = 4'd0;
      8'h16:   dig_val = 4'd1;
      8'h1E:   dig_val = 4'd2;
      8'h26:   dig_val = 4'd3;
      8'h25:   dig_val = 4'd4;
      8'h2E:   dig_val = 4'd5;
      8'h36:   dig_val = 4'd6;
      8'h3D:   dig_val = 4'd7;
      8'h3E:   dig_val = 4'd8;
      8'h46:   dig_val = 4'd9;
      default: dig_vld = 1'b0;
    endcase
  end

  assign dig_max   = (mode == M_BPM) ? 2'd3 : 2'd2;
  assign entry_nxt = entry_val * 10'd10 + {6'd0, dig_val};
  assign len_ok    = (entry_val >= 10'd1) && (entry_val <= 10'd16);

  assign acc_inc  = {20'd0, bpm, 2'b00};
  assign adv      = playing && (acc >= ACC_LIMIT);
  assign step_inc = (({1'b0, step} + 5'd1) >= len) ? 4'd0 : step + 4'd1;
  // Step value after this cycle's playback update; a length commit checks this
  // so a step that would land out of range is also caught.
  assign step_nxt = adv ? step_inc : step;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      mode      <= M_IDLE;
      brk       <= 1'b0;
      bpm       <= 10'd120;
      len       <= 5'd16;
      pat       <= '0;
      cur_trk   <= 2'd0;
      cur_col   <= 4'd0;
      playing   <= 1'b0;
      step      <= 4'd0;
      acc       <= 32'd0;
      entry_val <= 10'd0;
      dcnt      <= 2'd0;
    end else begin
      if (playing) begin
        if (adv) begin
          acc  <= acc - ACC_LIMIT + acc_inc;
          step <= step_inc;
        end else begin
          acc <= acc + acc_inc;
        end
      end

      if (sim_data_en) begin
        if (brk) begin
          brk <= 1'b0;              // byte after a break prefix is dropped
        end else if (code == 8'hF0) begin
          brk <= 1'b1;
        end else if (code != 8'hE0) begin
          case (mode)
            M_IDLE: begin
              case (code)
                8'h32: begin
                  mode      <= M_BPM;
                  entry_val <= 10'd0;
                  dcnt      <= 2'd0;
                end
                8'h4B: begin
                  mode      <= M_LEN;
                  entry_val <= 10'd0;
                  dcnt      <= 2'd0;
                end
                8'h3A: mode <= M_EDIT;
                8'h29: begin
                  playing <= !playing;
                  // Override this cycle's playback update: restart from step 0
                  // when starting, freeze in place when stopping.
                  if (!playing) begin
                    step <= 4'd0;
                    acc  <= 32'd0;
                  end else begin
                    step <= step;
                    acc  <= acc;
                  end
                end
                default: ;
              endcase
            end
            M_BPM, M_LEN: begin
              if (dig_vld) begin
                if (dcnt < dig_max) begin
                  entry_val <= entry_nxt;
                  dcnt      <= dcnt + 2'd1;
                end
              end else if (code == 8'h5A) begin
                if (mode == M_BPM) begin
                  if (entry_val != 10'd0) bpm <= entry_val;
                end else if (len_ok) begin
                  len <= entry_val[4:0];
                  if ({1'b0, step_nxt} >= entry_val[4:0]) step <= 4'd0;
                end
                mode <= M_IDLE;
              end else if (code == 8'h76) begin
                mode <= M_IDLE;
              end
            end
            M_EDIT: begin
              case (code)
                8'h23: cur_col <= cur_col + 4'd1;
                8'h1C: cur_col <= cur_col - 4'd1;
                8'h1B: cur_trk <= cur_trk + 2'd1;
                8'h1D: cur_trk <= cur_trk - 2'd1;
                8'h29: pat[cur_trk][cur_col] <= !pat[cur_trk][cur_col];
                8'h5A, 8'h3A: mode <= M_IDLE;
                default: ;
              endcase
            end
            default: mode <= M_IDLE;
          endcase
        end
      end
    end
  end

  always_comb begin
    gates = 4'd0;
    for (int t = 0; t < 4; t++) gates[t] = playing & pat[t][step];
  end

  assign LEDR = {(mode == M_EDIT), playing, step, gates};

  always_comb begin
    bpm_disp = (mode == M_BPM) ? entry_val : bpm;
    case (mode)
      M_EDIT:  len_disp = {2'b00, {1'b0, cur_col} + 5'd1};
      M_LEN:   len_disp = entry_val[6:0];
      default: len_disp = {2'b00, len};
    endcase
  end

  assign bpm_bcd = to_bcd3(bpm_disp);
  assign len_bcd = to_bcd2(len_disp);

  assign HEX2 = (bpm_bcd[11:8] == 4'd0) ? SEG_OFF : seg7(bpm_bcd[11:8]);
  assign HEX1 = (bpm_bcd[11:4] == 8'd0) ? SEG_OFF : seg7(bpm_bcd[7:4]);
  assign HEX0 = seg7(bpm_bcd[3:0]);
  assign HEX3 = (mode == M_EDIT) ? seg7({2'b00, cur_trk}) : SEG_OFF;
  assign HEX5 = (len_bcd[7:4] == 4'd0) ? SEG_OFF : seg7(len_bcd[7:4]);
  assign HEX4 = seg7(len_bcd[3:0]);

endmodule

// File: tb/tb_step_sequencer.sv
// Purpose: self-checking bench for step_sequencer (keyboard entry, editor, playback, reset).
// Latency: each byte is driven for one cycle and outputs are sampled on the following falling edge.
// Backpressure: not applicable; bytes are spaced one idle cycle apart.
module tb_step_sequencer;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
  localparam logic [6:0] S6 = 7'h02, S9 = 7'h10, BL = 7'h7F;

  typedef struct packed {
    logic [7:0]  code;
    logic [51:0] exp;   // {LEDR, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}
  } vec_t;

  logic       clk = 1'b0;
  logic [2:0] key = 3'b110;
  logic [8:0] sim_data = 9'd0;
  logic       sim_data_en = 1'b0;
  logic [9:0] ledr;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];

  step_sequencer #(.CLK_HZ(6000)) dut (
    .CLOCK_50   (clk),
    .KEY        (key),
    .sim_data   (sim_data),
    .sim_data_en(sim_data_en),
    .LEDR       (ledr),
    .HEX0       (hex0),
    .HEX1       (hex1),
    .HEX2       (hex2),
    .HEX3       (hex3),
    .HEX4       (hex4),
    .HEX5       (hex5)
  );

  always #5 clk = ~clk;

  function automatic logic [51:0] outs();
    return {ledr, hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    sim_data    = {1'b0, b};
    sim_data_en = 1'b1;
    @(negedge clk);
    sim_data_en = 1'b0;
    sim_data    = 9'd0;
  endtask

  task automatic add(input logic [7:0] c, input logic [9:0] l,
                     input logic [6:0] h5, input logic [6:0] h4, input logic [6:0] h3,
                     input logic [6:0] h2, input logic [6:0] h1, input logic [6:0] h0);
    vec_t v;
    v.code = c;
    v.exp  = {l, h5, h4, h3, h2, h1, h0};
    vecs.push_back(v);
  endtask

  // Wait for the step index to change; a missed step within the budget is a failure.
  task automatic wait_adv(input string name, output int cyc);
    logic [3:0] prev;
    prev = ledr[7:4];
    cyc  = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (ledr[7:4] != prev) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: step did not advance within 200 cycles (step %0d)", name, ledr[7:4]);
    end
  endtask

  initial begin
    int cyc;

    // Keyboard entry and editor vectors; outputs checked after every byte.
    add(8'h4B, 10'h000, BL, S0, BL, S1, S2, S0);  // enter length, buffer 0
    add(8'h16, 10'h000, BL, S1, BL, S1, S2, S0);
    add(8'h5A, 10'h000, BL, S1, BL, S1, S2, S0);  // length = 1
    add(8'h32, 10'h000, BL, S1, BL, BL, BL, S0);  // enter BPM
    add(8'h46, 10'h000, BL, S1, BL, BL, BL, S9);
    add(8'h46, 10'h000, BL, S1, BL, BL, S9, S9);
    add(8'h46, 10'h000, BL, S1, BL, S9, S9, S9);
    add(8'h46, 10'h000, BL, S1, BL, S9, S9, S9);  // 4th digit ignored
    add(8'h5A, 10'h000, BL, S1, BL, S9, S9, S9);  // BPM = 999
    add(8'h32, 10'h000, BL, S1, BL, BL, BL, S0);
    add(8'h45, 10'h000, BL, S1, BL, BL, BL, S0);
    add(8'h5A, 10'h000, BL, S1, BL, S9, S9, S9);  // 0 rejected, stays 999
    add(8'h3A, 10'h200, BL, S1, S0, S9, S9, S9);  // EDIT, cursor (0,0)
    add(8'h23, 10'h200, BL, S2, S0, S9, S9, S9);  // column 1
    add(8'h1B, 10'h200, BL, S2, S1, S9, S9, S9);  // track 1
    add(8'h29, 10'h200, BL, S2, S1, S9, S9, S9);  // pattern[1][1] = 1
    add(8'h1C, 10'h200, BL, S1, S1, S9, S9, S9);
    add(8'h1D, 10'h200, BL, S1, S0, S9, S9, S9);
    add(8'h29, 10'h200, BL, S1, S0, S9, S9, S9);  // pattern[0][0] = 1
    add(8'hF0, 10'h200, BL, S1, S0, S9, S9, S9);
    add(8'h5A, 10'h200, BL, S1, S0, S9, S9, S9);  // released key: dropped
    add(8'hE0, 10'h200, BL, S1, S0, S9, S9, S9);
    add(8'h1C, 10'h200, S1, S6, S0, S9, S9, S9);  // column wraps to 15
    add(8'h23, 10'h200, BL, S1, S0, S9, S9, S9);  // back to 0
    add(8'h1D, 10'h200, BL, S1, S3, S9, S9, S9);  // track wraps to 3
    add(8'h1B, 10'h200, BL, S1, S0, S9, S9, S9);
    add(8'h3A, 10'h000, BL, S1, BL, S9, S9, S9);  // leave EDIT
    add(8'h4B, 10'h000, BL, S0, BL, S9, S9, S9);
    add(8'h1E, 10'h000, BL, S2, BL, S9, S9, S9);
    add(8'h45, 10'h000, S2, S0, BL, S9, S9, S9);  // 20
    add(8'h26, 10'h000, S2, S0, BL, S9, S9, S9);  // 3rd digit ignored
    add(8'h5A, 10'h000, BL, S1, BL, S9, S9, S9);  // 20 rejected
    add(8'h4B, 10'h000, BL, S0, BL, S9, S9, S9);
    add(8'h26, 10'h000, BL, S3, BL, S9, S9, S9);
    add(8'h76, 10'h000, BL, S1, BL, S9, S9, S9);  // Esc discards
    add(8'h4B, 10'h000, BL, S0, BL, S9, S9, S9);
    add(8'h25, 10'h000, BL, S4, BL, S9, S9, S9);
    add(8'h5A, 10'h000, BL, S4, BL, S9, S9, S9);  // length = 4
    add(8'h32, 10'h000, BL, S4, BL, BL, BL, S0);
    add(8'h16, 10'h000, BL, S4, BL, BL, BL, S1);
    add(8'h76, 10'h000, BL, S4, BL, S9, S9, S9);  // Esc keeps 999

    // Reset state, during and after reset.
    repeat (2) @(negedge clk);
    check("reset_hold", outs(), {10'h000, S1, S6, BL, S1, S2, S0});
    key = 3'b111;
    @(negedge clk);
    check("reset_state", outs(), {10'h000, S1, S6, BL, S1, S2, S0});

    foreach (vecs[i]) begin
      send(vecs[i].code);
      check($sformatf("vec%0d_code%h", i, vecs[i].code), outs(), vecs[i].exp);
    end

    // Playback: length 4, BPM 999, pattern[0][0] and pattern[1][1] set.
    send(8'h29);
    check("play_start", ledr, 10'h101);
    wait_adv("adv_1", cyc);
    check("play_step1", ledr, 10'h112);
    check_range("period_1", cyc, 88, 93);
    wait_adv("adv_2", cyc);
    check("play_step2", ledr, 10'h120);
    check_range("period_2", cyc, 88, 93);
    wait_adv("adv_3", cyc);
    check("play_step3", ledr, 10'h130);
    wait_adv("adv_wrap", cyc);
    check("play_wrap", ledr, 10'h101);
    check_range("period_wrap", cyc, 88, 93);

    // Shrinking the length below the current step restarts at step 0.
    wait_adv("adv_a", cyc);
    wait_adv("adv_b", cyc);
    wait_adv("adv_c", cyc);
    check("pre_commit_step", ledr[7:4], 4'd3);
    send(8'h4B);
    send(8'h1E);
    send(8'h5A);
    check("len_commit_step0", ledr, 10'h101);

    // Prefixed bytes must not touch play state.
    send(8'hF0);
    send(8'h29);
    check("break_space", ledr[8], 1'b1);
    send(8'hE0);
    send(8'h74);
    check("ext_ignored", {ledr[9:8], hex3}, {2'b01, BL});

    // Stop: gates off, step frozen.
    send(8'h29);
    check("stop", ledr, 10'h000);
    repeat (150) @(negedge clk);
    check("stop_hold", ledr, 10'h000);

    // Restart, then reset asynchronously mid-playback.
    send(8'h29);
    check("restart", ledr, 10'h101);
    repeat (50) @(negedge clk);
    #2 key = 3'b110;
    #1;
    check("async_reset", outs(), {10'h000, S1, S6, BL, S1, S2, S0});
    @(negedge clk);
    key = 3'b111;
    send(8'h29);
    check("pattern_cleared", ledr, 10'h100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
